// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART receiver control slice:
//     - default widths (data bits, prescale/edge counter, bit counter)
//     - receiver state enum and the matching legacy-style state constants
//     - sample-edge helpers derived from the oversampling ratio P
//   Configuration macro used by the slice: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_PRESCALE_W = 6;
    localparam int UART_BIT_CNT_W  = 4;
    localparam int UART_STATE_W    = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } uart_rx_state_e;

    localparam logic [UART_STATE_W-1:0] ST_IDLE    = 3'(IDLE);
    localparam logic [UART_STATE_W-1:0] ST_START   = 3'(START);
    localparam logic [UART_STATE_W-1:0] ST_DATA    = 3'(DATA);
    localparam logic [UART_STATE_W-1:0] ST_PARITY  = 3'(PARITY);
    localparam logic [UART_STATE_W-1:0] ST_STOP    = 3'(STOP);
    localparam logic [UART_STATE_W-1:0] ST_ERR_CHK = 3'(ERR_CHK);

    // First of the three sampler edges (P/2-1, P/2, P/2+1).
    function automatic logic [UART_PRESCALE_W-1:0] samp_edge_first(input logic [UART_PRESCALE_W-1:0] p);
        return (p >> 1) - UART_PRESCALE_W'(1);
    endfunction

    // Edge on which the checker / deserializer enables fire, one past the last sample.
    function automatic logic [UART_PRESCALE_W-1:0] chk_edge(input logic [UART_PRESCALE_W-1:0] p);
        return (p >> 1) + UART_PRESCALE_W'(2);
    endfunction

    // STOP is left half a bit early so a following start bit is not missed.
    function automatic logic [UART_PRESCALE_W-1:0] stop_exit_edge(input logic [UART_PRESCALE_W-1:0] p);
        return (p >> 1) + UART_PRESCALE_W'(3);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
//   Bundles the receiver control signals between the line/datapath side
//   (master) and the control FSM (slave).
//   master drives : RX_IN, Prescale, PAR_EN, par_err, strt_glitch, stp_err
//   slave drives  : edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
//                   par_chk_en, stp_chk_en, data_valid, state_dbg
//   Protocol: there is no back-pressure. data_valid is a one-cycle strobe with
//   no ready; the consumer must take the frame in the cycle it is high. The
//   *_chk_en / deser_en signals are likewise single-cycle strobes, and the
//   checker flags are expected to be registered, valid the cycle after.
//   Configuration macro affecting users of this bundle: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  par_err;
    logic                  strt_glitch;
    logic                  stp_err;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;
    logic [2:0]            state_dbg;

    modport master (
        output RX_IN, Prescale, PAR_EN, par_err, strt_glitch, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, state_dbg
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, par_err, strt_glitch, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, state_dbg
    );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
//   Oversampling edge counter plus frame bit counter.
//   CLK          in  system clock
//   RST          in  asynchronous active-low reset
//   en_i         in  advance the counters this cycle
//   clr_i        in  synchronous clear (wins over en_i)
//   edge_last_i  in  last edge index of a bit (P-1)
//   edge_cnt_o   out edge index within the current bit
//   bit_cnt_o    out bit index within the frame
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] edge_last_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [BIT_CNT_W-1:0]  bit_cnt_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (en_i) begin
            if (edge_q == edge_last_i) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_CNT_W'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   UART receiver control FSM. Walks each frame through START, DATA, optional
//   PARITY and STOP, pulses the sampler / deserializer / checker enables and
//   raises data_valid for one cycle on an error-free frame.
//   CLK  in  system clock, rising edge
//   RST  in  asynchronous active-low reset
//   bus  uart_rx_ctrl_if.slave: RX_IN, Prescale, PAR_EN and checker flags in;
//        edge_cnt, bit_cnt, enables, data_valid and state_dbg out
//   Macro UART_RX_PARITY_EN: when defined, PAR_EN selects a PARITY bit and
//   par_err gates data_valid; when undefined, both are ignored and par_chk_en
//   stays 0.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = UART_PRESCALE_W,
    parameter int BIT_CNT_W  = UART_BIT_CNT_W
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  in_frame;
    logic                  start_go;
    logic                  last_edge;
    logic                  at_chk;
    logic                  par_ok;

    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);

    // A new frame starts from IDLE or straight out of ERR_CHK on a low line.
    assign start_go = ((state_q == ST_IDLE) || (state_q == ST_ERR_CHK)) && !bus.RX_IN;

    // Prescale is frozen for the whole frame so a mid-frame change cannot
    // corrupt the edge arithmetic.
    assign presc_d = start_go ? bus.Prescale : presc_q;

    assign last_edge = (edge_cnt == (presc_q - PRESCALE_W'(1)));
    assign at_chk    = (edge_cnt == chk_edge(presc_q));

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;

    assign par_en_d = start_go ? bus.PAR_EN : par_en_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) par_en_q <= 1'b0;
        else      par_en_q <= par_en_d;
    end

    assign par_ok         = !(par_en_q && bus.par_err);
    assign bus.par_chk_en = (state_q == ST_PARITY) && at_chk;
`else
    logic unused_par;

    assign unused_par     = bus.PAR_EN ^ bus.par_err;
    assign par_ok         = 1'b1;
    assign bus.par_chk_en = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.RX_IN) state_d = ST_START;
            end
            ST_START: begin
                if (last_edge) state_d = bus.strt_glitch ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (last_edge && (bit_cnt == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (last_edge) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (edge_cnt == stop_exit_edge(presc_q)) state_d = ST_ERR_CHK;
            end
            ST_ERR_CHK: begin
                state_d = bus.RX_IN ? ST_IDLE : ST_START;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    // Counters only run inside a frame and sit at zero otherwise, so every
    // frame (including one entered from ERR_CHK) starts from edge 0, bit 0.
    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .CLK         (CLK),
        .RST         (RST),
        .en_i        (in_frame),
        .clr_i       (!in_frame),
        .edge_last_i (presc_q - PRESCALE_W'(1)),
        .edge_cnt_o  (edge_cnt),
        .bit_cnt_o   (bit_cnt)
    );

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.dat_samp_en = in_frame;
    assign bus.deser_en    = (state_q == ST_DATA) && at_chk;
    assign bus.strt_chk_en = (state_q == ST_START) && at_chk;
    assign bus.stp_chk_en  = (state_q == ST_STOP) && at_chk;
    assign bus.data_valid  = (state_q == ST_ERR_CHK) && !bus.stp_err && par_ok;
    assign bus.state_dbg   = state_q;

endmodule
